// File: rtl/rca_word_sequencer_if.sv
// Operand/result handshake bundle for rca_word_sequencer.
// master drives operands and out_ready; slave is the sequencer itself.
interface rca_word_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [WORDS*WIDTH-1:0] a;
  logic [WORDS*WIDTH-1:0] b;
  logic                   cin;
  logic                   sub;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORDS*WIDTH-1:0] sum;
  logic                   cout;
  logic                   ovf;
  logic                   busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/rca_word_sequencer.sv
// Wide adder/subtractor that reuses one WIDTH-bit ripple-carry slice once per
// word, LSB word first, with the inter-slice carry held in a register.
module rca_word_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca_word_sequencer_if.slave  bus
);

  localparam int unsigned N    = WORDS * WIDTH;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;      // B already inverted for subtraction
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  int unsigned     base;
  logic [WIDTH-1:0] slice_a, slice_b, slice_s;
  logic [WIDTH:0]   chain;
  logic             last;

  // Shared ripple-carry slice operating on the word selected by idx_q.
  always_comb begin
    base     = 32'(idx_q) * WIDTH;
    slice_a  = a_q[base +: WIDTH];
    slice_b  = b_q[base +: WIDTH];
    chain    = '0;
    slice_s  = '0;
    chain[0] = carry_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      slice_s[i]   = slice_a[i] ^ slice_b[i] ^ chain[i];
      chain[i+1]   = (slice_a[i] & slice_b[i]) | ((slice_a[i] ^ slice_b[i]) & chain[i]);
    end
    last = (idx_q == IdxW'(WORDS - 1));
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {N{bus.sub}};
          // Subtraction is A + ~B + 1, so cin is replaced by 1.
          carry_d = bus.sub | bus.cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[base +: WIDTH] = slice_s;
        carry_d              = chain[WIDTH];
        if (last) begin
          cout_d  = chain[WIDTH];
          ovf_d   = (a_q[N-1] == b_q[N-1]) & (slice_s[WIDTH-1] != a_q[N-1]);
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; everything clears asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule
